// File: rtl/song_sequencer_pkg.sv
// song_pkg: shared types and constants for the song sequencer.
//   state_t  - sequencer FSM states (IDLE / PLAY / PAUSE)
//   ADDR_W   - ROM step address width
//   NOTE_W   - note code width (0 = rest)
//   LEN0_DEF / LEN1_DEF - default step counts of the two songs
package song_pkg;

  localparam int ADDR_W   = 9;
  localparam int NOTE_W   = 8;
  localparam int LEN0_DEF = 365;
  localparam int LEN1_DEF = 262;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: song ROM bus between the sequencer and the note ROM.
//   rom_sel  - song number, selects which ROM is read
//   rom_addr - step address
//   rom_note - registered ROM data, valid one clk after rom_addr
// Modports: master (sequencer side), slave (ROM side).
interface song_sequencer_if;

  logic                       rom_sel;
  logic [song_pkg::ADDR_W-1:0] rom_addr;
  logic [song_pkg::NOTE_W-1:0] rom_note;

  modport master (output rom_sel, output rom_addr, input rom_note);
  modport slave  (input rom_sel, input rom_addr, output rom_note);

endinterface

// File: rtl/song_sequencer_tempo_tick.sv
// tempo_tick: step-rate divider for the song sequencer.
//   clk, rst_n - clock, asynchronous active-low reset
//   en_i       - count enable (sequencer is playing); count holds when low
//   clr_i      - synchronous clear of the count
//   tempo_i    - tempo prescale, step period TICK_DIV*(tempo_i+1)
//                (present only when SONG_TEMPO_EN is defined)
//   tick_o     - one-cycle pulse on the last count of a step
// Optional feature macro: SONG_TEMPO_EN.
module tempo_tick #(
  parameter int TICK_DIV = 6250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
`ifdef SONG_TEMPO_EN
  input  logic [1:0] tempo_i,
`endif
  output logic       tick_o
);

  // Wide enough for the slowest tempo (x4) in either build.
  localparam int CNT_W = $clog2(TICK_DIV * 4 + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last;

`ifdef SONG_TEMPO_EN
  logic [1:0] tempo_q, tempo_d;

  // Tempo is captured while cleared and re-captured on every tick, so a
  // change only takes effect at a step boundary.
  assign tempo_d = (clr_i || tick_o) ? tempo_i : tempo_q;
  assign last    = CNT_W'(TICK_DIV * (int'(tempo_q) + 1) - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tempo_q <= 2'd0;
    else        tempo_q <= tempo_d;
  end
`else
  assign last = CNT_W'(TICK_DIV - 1);
`endif

  assign tick_o = en_i && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) cnt_d = '0;
    else if (en_i)       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: steps through a song ROM at a fixed step rate and drives
// note codes to a tone generator.
//   clk, rst_n  - clock, asynchronous active-low reset
//   play_pause  - pulse: IDLE->PLAY (latches song_sel), PLAY<->PAUSE
//   stop        - pulse: PLAY/PAUSE -> IDLE; wins over play_pause
//   song_sel    - song number, sampled only when leaving IDLE
//   loop_en     - restart the song at its end instead of stopping
//   tempo       - step period multiplier-1 (only with SONG_TEMPO_EN)
//   rom         - ROM bus (rom_sel, rom_addr out; rom_note in)
//   note        - note code, 0 = rest
//   playing     - high in PLAY
//   done        - one-cycle pulse when the last step completes
// Optional feature macro: SONG_TEMPO_EN.
module song_sequencer
  import song_pkg::*;
#(
  parameter int TICK_DIV = 6250000,
  parameter int LEN0     = LEN0_DEF,
  parameter int LEN1     = LEN1_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play_pause,
  input  logic              stop,
  input  logic              song_sel,
  input  logic              loop_en,
`ifdef SONG_TEMPO_EN
  input  logic [1:0]        tempo,
`endif
  song_sequencer_if.master  rom,
  output logic [NOTE_W-1:0] note,
  output logic              playing,
  output logic              done
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                sel_q, sel_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                done_q, done_d;
  logic                fresh_q;
  logic                tick, tick_en, tick_clr;
  logic [ADDR_W-1:0]   len_last;
  logic                at_last;

  tempo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (tick_en),
    .clr_i  (tick_clr),
`ifdef SONG_TEMPO_EN
    .tempo_i(tempo),
`endif
    .tick_o (tick)
  );

  assign len_last = sel_q ? ADDR_W'(LEN1 - 1) : ADDR_W'(LEN0 - 1);
  // >= rather than == so the address can never run past the song end.
  assign at_last  = (addr_q >= len_last);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: stop beats everything, end-of-song beats pause.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (play_pause && !stop)              state_d = ST_PLAY;
      ST_PLAY:  if (stop)                             state_d = ST_IDLE;
                else if (tick && at_last && !loop_en) state_d = ST_IDLE;
                else if (play_pause)                  state_d = ST_PAUSE;
      ST_PAUSE: if (stop)                             state_d = ST_IDLE;
                else if (play_pause)                  state_d = ST_PLAY;
      default:                                        state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: divider runs only in PLAY and is held clear in IDLE.
  always_comb begin
    playing  = (state_q == ST_PLAY);
    tick_en  = (state_q == ST_PLAY);
    tick_clr = (state_q == ST_IDLE);
  end

  // Step address, song latch, done pulse and note output.
  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    done_d = 1'b0;
    note_d = '0;
    if (state_q == ST_IDLE && state_d == ST_PLAY) begin
      sel_d  = song_sel;
      addr_d = '0;
    end
    if (state_q == ST_PLAY && !stop && tick) begin
      if (at_last) begin
        done_d = 1'b1;
        addr_d = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
    if (state_d == ST_IDLE) addr_d = '0;
    // ROM data lags the address by one clk; fresh_q masks the first cycle
    // after entering PLAY so the stale word never reaches note.
    if (state_q == ST_PLAY && state_d == ST_PLAY && !fresh_q)
      note_d = rom.rom_note;
  end

  // Pipeline stage: ROM data -> note register (address + 2 clk)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      sel_q   <= 1'b0;
      note_q  <= '0;
      done_q  <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      note_q  <= note_d;
      done_q  <= done_d;
      fresh_q <= (state_q != ST_PLAY);
    end
  end

  assign rom.rom_sel  = sel_q;
  assign rom.rom_addr = addr_q;
  assign note         = note_q;
  assign done         = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;
  import song_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              play_pause;
  logic              stop;
  logic              song_sel;
  logic              loop_en;
`ifdef SONG_TEMPO_EN
  logic [1:0]        tempo;
`endif
  logic [NOTE_W-1:0] note;
  logic              playing;
  logic              done;

  song_sequencer_if rif ();

  song_sequencer #(.TICK_DIV(4), .LEN0(3), .LEN1(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .play_pause(play_pause),
    .stop      (stop),
    .song_sel  (song_sel),
    .loop_en   (loop_en),
`ifdef SONG_TEMPO_EN
    .tempo     (tempo),
`endif
    .rom       (rif),
    .note      (note),
    .playing   (playing),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: registered read, one clk latency.
  logic [7:0] rom0 [0:2] = '{8'd10, 8'd11, 8'd12};
  logic [7:0] rom1 [0:4] = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24};

  always @(posedge clk) begin
    if (rif.rom_sel == 1'b0)
      rif.rom_note <= (rif.rom_addr < 9'd3) ? rom0[rif.rom_addr[1:0]] : 8'hEE;
    else
      rif.rom_note <= (rif.rom_addr < 9'd5) ? rom1[rif.rom_addr[2:0]] : 8'hEE;
  end

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int d0;
  logic [7:0] exp_q [$];
  logic [7:0] prev_note = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: every new non-rest note pops the next expected note.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done === 1'b1) done_cnt++;
      if (note !== prev_note && note !== 8'd0) begin
        if (exp_q.size() == 0) chk("unexpected_note", note, 0);
        else                   chk("sb_note", note, exp_q.pop_front());
      end
    end
    prev_note = note;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pp();
    @(negedge clk); play_pause = 1'b1;
    @(negedge clk); play_pause = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; play_pause = 1'b0; stop = 1'b0; song_sel = 1'b0; loop_en = 1'b0;
`ifdef SONG_TEMPO_EN
    tempo = 2'd0;
`endif
    wait_neg(3);
    chk("rst_playing", playing, 0);
    chk("rst_note", note, 0);
    chk("rst_addr", rif.rom_addr, 0);
    chk("rst_sel", rif.rom_sel, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    wait_neg(2);

    // Single play-through of song 0.
    exp_q.push_back(8'd10); exp_q.push_back(8'd11); exp_q.push_back(8'd12);
    d0 = done_cnt;
    pulse_pp();
    chk("t1_playing", playing, 1);
    chk("t1_addr0", rif.rom_addr, 0);
    wait_neg(2);
    chk("t1_note10", note, 10);
    wait_neg(4);
    chk("t1_note11", note, 11);
    chk("t1_addr1", rif.rom_addr, 1);
    wait_neg(4);
    chk("t1_note12", note, 12);
    chk("t1_addr2", rif.rom_addr, 2);
    wait_neg(2);
    chk("t1_done", done, 1);
    chk("t1_idle", playing, 0);
    chk("t1_note_rest", note, 0);
    chk("t1_addr_rst", rif.rom_addr, 0);
    wait_neg(1);
    chk("t1_done_clr", done, 0);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_queue", exp_q.size(), 0);

    // Looping play.
    loop_en = 1'b1;
    exp_q.push_back(8'd10); exp_q.push_back(8'd11); exp_q.push_back(8'd12);
    exp_q.push_back(8'd10); exp_q.push_back(8'd11);
    d0 = done_cnt;
    pulse_pp();
    wait_neg(12);
    chk("t2_done_wrap", done, 1);
    chk("t2_playing_wrap", playing, 1);
    chk("t2_addr_wrap", rif.rom_addr, 0);
    chk("t2_note_wrap", note, 12);
    wait_neg(2);
    chk("t2_note10", note, 10);
    wait_neg(4);
    chk("t2_note11", note, 11);
    chk("t2_playing", playing, 1);
    wait_neg(1);
    chk("t2_done_cnt", done_cnt - d0, 1);
    chk("t2_queue", exp_q.size(), 0);
    pulse_stop();
    chk("t2_stop_playing", playing, 0);
    chk("t2_stop_note", note, 0);
    chk("t2_stop_addr", rif.rom_addr, 0);
    loop_en = 1'b0;
    wait_neg(2);

    // Pause at step 1 and resume.
    exp_q.push_back(8'd10); exp_q.push_back(8'd11);
    exp_q.push_back(8'd11); exp_q.push_back(8'd12);
    d0 = done_cnt;
    pulse_pp();
    wait_neg(5);
    chk("t3_addr1", rif.rom_addr, 1);
    pulse_pp();
    chk("t3_pause_playing", playing, 0);
    chk("t3_pause_note", note, 0);
    chk("t3_pause_addr", rif.rom_addr, 1);
    wait_neg(20);
    chk("t3_hold_note", note, 0);
    chk("t3_hold_addr", rif.rom_addr, 1);
    chk("t3_hold_playing", playing, 0);
    pulse_pp();
    chk("t3_resume_playing", playing, 1);
    chk("t3_resume_addr", rif.rom_addr, 1);
    wait_neg(1);
    chk("t3_tick_kept", rif.rom_addr, 2);
    chk("t3_resume_note0", note, 0);
    wait_neg(1);
    chk("t3_note11", note, 11);
    wait_neg(1);
    chk("t3_note12", note, 12);
    wait_neg(2);
    chk("t3_done", done, 1);
    chk("t3_idle", playing, 0);
    wait_neg(1);
    chk("t3_done_cnt", done_cnt - d0, 1);
    chk("t3_queue", exp_q.size(), 0);

    // stop and play_pause together during PLAY.
    exp_q.push_back(8'd10);
    pulse_pp();
    wait_neg(4);
    chk("t4_addr1", rif.rom_addr, 1);
    stop = 1'b1; play_pause = 1'b1;
    @(negedge clk); stop = 1'b0; play_pause = 1'b0;
    chk("t4_playing", playing, 0);
    chk("t4_addr", rif.rom_addr, 0);
    chk("t4_note", note, 0);
    wait_neg(3);
    chk("t4_not_paused", rif.rom_addr, 0);
    exp_q.push_back(8'd10);
    pulse_pp();
    chk("t4_restart_addr", rif.rom_addr, 0);
    wait_neg(2);
    chk("t4_restart_note", note, 10);
    pulse_stop();
    chk("t4_stop", playing, 0);
    wait_neg(2);

    // song_sel change mid-song, then reset mid-song.
    song_sel = 1'b1;
    exp_q.push_back(8'd20); exp_q.push_back(8'd21);
    d0 = done_cnt;
    pulse_pp();
    chk("t5_sel", rif.rom_sel, 1);
    wait_neg(2);
    chk("t5_note20", note, 20);
    song_sel = 1'b0;
    wait_neg(4);
    chk("t5_note21", note, 21);
    chk("t5_sel_kept", rif.rom_sel, 1);
    chk("t5_addr1", rif.rom_addr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_playing", playing, 0);
    chk("t5_rst_note", note, 0);
    chk("t5_rst_addr", rif.rom_addr, 0);
    chk("t5_rst_sel", rif.rom_sel, 0);
    chk("t5_rst_done", done, 0);
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(2);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_idle", playing, 0);
    chk("t5_queue", exp_q.size(), 0);

`ifdef SONG_TEMPO_EN
    // Tempo prescale: period 4*(2+1) = 12 clk.
    tempo = 2'd2;
    exp_q.push_back(8'd10); exp_q.push_back(8'd11);
    pulse_pp();
    wait_neg(2);
    chk("t6_note10", note, 10);
    wait_neg(9);
    chk("t6_addr_hold", rif.rom_addr, 0);
    wait_neg(1);
    chk("t6_addr_step", rif.rom_addr, 1);
    wait_neg(2);
    chk("t6_note11", note, 11);
    pulse_stop();
    tempo = 2'd0;
`endif

    wait_neg(2);
    chk("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
